// File: rtl/sha256_padder_if.sv
// sha256_padder_if: control and shared-memory bus between the padder and its surroundings
interface sha256_padder_if;
  logic        start;
  logic [15:0] input_addr;
  logic [15:0] pad_addr;
  logic [31:0] memory_read_data;
  logic        done;
  logic        memory_clk;
  logic        enable_write;
  logic [15:0] memory_addr;
  logic [31:0] memory_write_data;
  logic [7:0]  num_blocks;
  modport master (
    output start, input_addr, pad_addr, memory_read_data,
    input  done, memory_clk, enable_write, memory_addr, memory_write_data, num_blocks
  );
  modport slave (
    input  start, input_addr, pad_addr, memory_read_data,
    output done, memory_clk, enable_write, memory_addr, memory_write_data, num_blocks
  );
endinterface

// File: rtl/sha256_padder.sv
// sha256_padder: copies a raw message into place and appends SHA-256 padding in shared word memory
module sha256_padder #(
  parameter int NUM_OF_WORDS = 40
) (
  input logic           clk,
  input logic           rst,
  sha256_padder_if.slave bus
);
  localparam logic [7:0]  NB = 8'((NUM_OF_WORDS + 18) / 16);
  localparam logic [15:0] P = 16'(16 * ((NUM_OF_WORDS + 18) / 16));
  localparam logic [15:0] P1 = P - 16'd1;
  localparam logic [15:0] P2 = P - 16'd2;
  localparam logic [15:0] LAST = 16'(NUM_OF_WORDS - 1);
  localparam logic [15:0] MARK = 16'(NUM_OF_WORDS);
  localparam logic [63:0] L = 64'(NUM_OF_WORDS) * 64'd32;
  typedef enum logic [1:0] {IDLE, COPY_RD, COPY_WR, PAD} state_t;
  state_t      r_state;
  logic [15:0] r_i, r_in, r_pad;
  logic [31:0] w_pad_data;
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_i     <= 16'd0;
      r_in    <= 16'd0;
      r_pad   <= 16'd0;
    end else
      case (r_state)
        IDLE: if (bus.start) begin
          r_in    <= bus.input_addr;
          r_pad   <= bus.pad_addr;
          r_i     <= 16'd0;
          r_state <= COPY_RD;
        end
        COPY_RD: r_state <= COPY_WR;
        COPY_WR: begin
          r_i     <= r_i + 16'd1;
          r_state <= (r_i == LAST) ? PAD : COPY_RD;
        end
        PAD: begin
          r_i <= r_i + 16'd1;
          if (r_i == P1) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
  // length fits in 64 bits for every legal size, so both halves come straight from L
  assign w_pad_data = (r_i == MARK) ? 32'h8000_0000 :
                      (r_i == P2)   ? L[63:32] :
                      (r_i == P1)   ? L[31:0] : 32'd0;
  assign bus.done              = r_state == IDLE;
  assign bus.memory_clk        = clk;
  assign bus.enable_write      = r_state == COPY_WR || r_state == PAD;
  assign bus.memory_addr       = (r_state == COPY_RD) ? r_in + r_i :
                                 bus.enable_write     ? r_pad + r_i : 16'd0;
  assign bus.memory_write_data = (r_state == COPY_WR) ? bus.memory_read_data :
                                 (r_state == PAD)     ? w_pad_data : 32'd0;
  assign bus.num_blocks        = NB;
endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: three padder sizes on private memories, write scoreboard plus final memory table
module tb_sha256_padder;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [2:0]  st = '0, done_w, we_w, mclk_w;
  logic [15:0] ia [3], pa [3], ma_w [3];
  logic [31:0] rd [3], wd_w [3];
  logic [7:0]  nb_w [3];
  logic [31:0] mem [3][65536];
  logic        pk_en = 0;
  int          pk_k;
  logic [15:0] pk_a;
  logic [31:0] pk_d;
  int errors = 0, checks = 0;
  int nw [3] = '{40, 13, 14};
  int pw [3] = '{48, 16, 32};
  logic [7:0] nbx [3] = '{8'd3, 8'd1, 8'd2};
  typedef struct {int k; logic [15:0] a; logic [31:0] d;} wr_t;
  wr_t q [$];
  wr_t tbl [$];

  for (genvar k = 0; k < 3; k++) begin : g
    sha256_padder_if bus ();
    sha256_padder #(.NUM_OF_WORDS(k == 0 ? 40 : k == 1 ? 13 : 14)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
    );
    assign bus.start            = st[k];
    assign bus.input_addr       = ia[k];
    assign bus.pad_addr         = pa[k];
    assign bus.memory_read_data = rd[k];
    assign done_w[k] = bus.done;
    assign we_w[k]   = bus.enable_write;
    assign mclk_w[k] = bus.memory_clk;
    assign ma_w[k]   = bus.memory_addr;
    assign wd_w[k]   = bus.memory_write_data;
    assign nb_w[k]   = bus.num_blocks;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      rd[k] <= mem[k][ma_w[k]];
      if (we_w[k]) mem[k][ma_w[k]] <= wd_w[k];
    end
    if (pk_en) mem[pk_k][pk_a] <= pk_d;
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", n, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      if (we_w[k]) begin
        wr_t e;
        if (q.size() == 0 || q[0].k != k) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: dut %0d addr %h data %h, none required", k, ma_w[k], wd_w[k]);
        end else begin
          e = q.pop_front();
          chk("wr_addr", 32'(ma_w[k]), 32'(e.a));
          chk("wr_data", wd_w[k], e.d);
        end
      end
  end

  task automatic poke(int k, logic [15:0] a, logic [31:0] d);
    pk_k = k; pk_a = a; pk_d = d; pk_en = 1;
    @(posedge clk);
    #1 pk_en = 0;
  endtask

  task automatic load(int k, logic [15:0] base, logic [31:0] seed);
    for (int i = 0; i < nw[k]; i++) poke(k, base + 16'(i), seed + 32'(i));
  endtask

  task automatic push(int k, logic [15:0] pad, logic [31:0] seed);
    for (int i = 0; i < pw[k]; i++) begin
      wr_t e;
      e.k = k;
      e.a = pad + 16'(i);
      e.d = (i < nw[k]) ? seed + 32'(i) : (i == nw[k]) ? 32'h8000_0000 :
            (i == pw[k] - 1) ? 32'(nw[k] * 32) : 32'd0;
      q.push_back(e);
    end
  endtask

  task automatic start_run(int k, logic [15:0] in_a, logic [15:0] pad, logic [31:0] seed, bit hold);
    ia[k] = in_a;
    pa[k] = pad;
    push(k, pad, seed);
    st[k] = 1;
    @(posedge clk);
    #1 if (!hold) st[k] = 0;
  endtask

  task automatic wait_done(int k, int exp, string n);
    int c = 0;
    while (!done_w[k] && c < 200) begin
      @(posedge clk);
      #1 c++;
    end
    chk(n, 32'(c), 32'(exp));
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin ia[k] = 16'h1234; pa[k] = 16'h5678; end
    tbl = '{
      '{0, 16'h0100, 32'h1},        '{0, 16'h0127, 32'h28},       '{0, 16'h0128, 32'h8000_0000},
      '{0, 16'h0129, 32'h0},        '{0, 16'h012E, 32'h0},        '{0, 16'h012F, 32'h500},
      '{0, 16'h0427, 32'h28},       '{0, 16'h042F, 32'h500},      '{0, 16'h0500, 32'hB000},
      '{0, 16'h052F, 32'h500},      '{0, 16'h0727, 32'h28},       '{0, 16'hFFF0, 32'hA000},
      '{0, 16'hFFFF, 32'hA00F},     '{0, 16'h0000, 32'hA010},     '{0, 16'h0017, 32'hA027},
      '{0, 16'h0018, 32'h8000_0000},'{0, 16'h001F, 32'h500},
      '{1, 16'h020C, 32'hD},        '{1, 16'h020D, 32'h8000_0000},'{1, 16'h020E, 32'h0},
      '{1, 16'h020F, 32'h1A0},
      '{2, 16'h030D, 32'hE},        '{2, 16'h030E, 32'h8000_0000},'{2, 16'h030F, 32'h0},
      '{2, 16'h031D, 32'h0},        '{2, 16'h031F, 32'h1C0}
    };
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_done", 32'(done_w[k]), 32'd1);
      chk("rst_we", 32'(we_w[k]), 32'd0);
      chk("rst_addr", 32'(ma_w[k]), 32'd0);
      chk("rst_wdata", wd_w[k], 32'd0);
      chk("num_blocks", 32'(nb_w[k]), 32'(nbx[k]));
    end
    chk("memory_clk", 32'(mclk_w), 32'({3{clk}}));
    rst = 0;
    load(0, 16'h0000, 32'h1);
    load(1, 16'h0000, 32'h1);
    load(2, 16'h0000, 32'h1);
    load(0, 16'h2000, 32'hA000);
    load(0, 16'h3000, 32'hB000);
    start_run(0, 16'h0000, 16'h0100, 32'h1, 0);
    wait_done(0, 88, "latency_40");
    start_run(1, 16'h0000, 16'h0200, 32'h1, 0);
    wait_done(1, 29, "latency_13");
    start_run(2, 16'h0000, 16'h0300, 32'h1, 0);
    wait_done(2, 46, "latency_14");
    start_run(0, 16'h0000, 16'h0600, 32'h1, 0);
    repeat (29) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1;
    chk("midrst_we", 32'(we_w[0]), 32'd0);
    chk("midrst_done", 32'(done_w[0]), 32'd1);
    chk("midrst_addr", 32'(ma_w[0]), 32'd0);
    rst = 0;
    q.delete();
    start_run(0, 16'h0000, 16'h0700, 32'h1, 0);
    wait_done(0, 88, "latency_after_reset");
    start_run(0, 16'h0000, 16'h0400, 32'h1, 1);
    repeat (10) @(posedge clk);
    #1;
    pa[0] = 16'h0500;
    ia[0] = 16'h3000;
    wait_done(0, 78, "latency_held_start");
    push(0, 16'h0500, 32'hB000);
    @(posedge clk);
    #1 chk("restart_on_held_start", 32'(done_w[0]), 32'd0);
    st[0] = 0;
    wait_done(0, 88, "latency_second_run");
    start_run(0, 16'h2000, 16'hFFF0, 32'hA000, 0);
    wait_done(0, 88, "latency_wrap");
    for (int i = 0; i < tbl.size(); i++)
      chk($sformatf("mem%0d[%h]", tbl[i].k, tbl[i].a), mem[tbl[i].k][tbl[i].a], tbl[i].d);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
